// File: rtl/fetch_unit.sv
// Y86-64 SEQ fetch: pulls bytes from a byte-wide imem, splits icode/ifun/rA/rB/valC, computes valP.
// Latency N+1 cycles for an N-byte instruction at zero wait; outputs held while out_valid & !out_ready.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  input  logic        imem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  in_code,
  output logic [3:0]  ifun,
  output logic [3:0]  r_a,
  output logic [3:0]  r_b,
  output logic [63:0] val_c,
  output logic [63:0] val_p,
  output logic [2:0]  stat,
  input  logic        pc_load,
  input  logic [63:0] pc_next,
  output logic [63:0] pc
);

  typedef enum logic [1:0] {FETCH, VALID, WAIT_PC, HALT} state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t      state, state_nxt;
  logic        boot_q;
  logic [3:0]  byte_idx;
  logic [3:0]  cur_icode;
  logic [3:0]  ilen;
  logic [3:0]  vc_lo;
  logic [2:0]  vc_off;
  logic        icode_bad, has_regs, vc_hit;
  logic        byte_fire, err_fire, data_fire;
  logic        last_byte, fetch_done, restart;

  assign byte_fire  = imem_req & imem_ack;
  assign err_fire   = byte_fire & imem_err;
  assign data_fire  = byte_fire & ~imem_err;
  // Byte 0 decides the length while it is on the bus; later bytes use the stored icode.
  assign cur_icode  = (byte_idx == 4'd0) ? imem_data[7:4] : in_code;

  always_comb begin
    ilen      = 4'd1;
    icode_bad = 1'b0;
    has_regs  = 1'b0;
    vc_lo     = 4'd0;
    case (cur_icode)
      4'h0, 4'h1, 4'h9:       ilen = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin ilen = 4'd2;  has_regs = 1'b1; end
      4'h7, 4'h8:             begin ilen = 4'd9;  vc_lo = 4'd1; end
      4'h3, 4'h4, 4'h5:       begin ilen = 4'd10; has_regs = 1'b1; vc_lo = 4'd2; end
      default:                icode_bad = 1'b1;
    endcase
  end

  assign vc_off     = 3'(byte_idx - vc_lo);
  assign vc_hit     = (vc_lo != 4'd0) && (byte_idx >= vc_lo);
  assign last_byte  = icode_bad | ((byte_idx + 4'd1) == ilen);
  assign fetch_done = err_fire | (data_fire & last_byte);
  assign restart    = pc_load & (((state == VALID) & out_ready & (stat == STAT_AOK)) |
                                 (state == WAIT_PC));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (fetch_done) state_nxt = VALID;
      VALID:   if (out_ready) begin
                 if (stat != STAT_AOK) state_nxt = HALT;
                 else if (pc_load)     state_nxt = FETCH;
                 else                  state_nxt = WAIT_PC;
               end
      WAIT_PC: if (pc_load) state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end

  always_comb begin
    out_valid = (state == VALID);
    imem_addr = pc + {60'd0, byte_idx};
  end

  // boot_q holds off the first request so a reset exit behaves like any other FETCH entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      boot_q   <= 1'b1;
      imem_req <= 1'b0;
    end else begin
      boot_q   <= 1'b0;
      imem_req <= (state == FETCH) & ~fetch_done & ~boot_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      byte_idx <= 4'd0;
      in_code  <= 4'h0;
      ifun     <= 4'h0;
      r_a      <= 4'hF;
      r_b      <= 4'hF;
      val_c    <= 64'd0;
      val_p    <= 64'd0;
      stat     <= STAT_AOK;
    end else if (restart) begin
      pc       <= pc_next;
      byte_idx <= 4'd0;
      in_code  <= 4'h0;
      ifun     <= 4'h0;
      r_a      <= 4'hF;
      r_b      <= 4'hF;
      val_c    <= 64'd0;
      stat     <= STAT_AOK;
    end else if (err_fire) begin
      stat  <= STAT_ADR;
      val_p <= imem_addr;
    end else if (data_fire) begin
      byte_idx <= byte_idx + 4'd1;
      if (byte_idx == 4'd0) begin
        in_code <= imem_data[7:4];
        ifun    <= imem_data[3:0];
      end
      if (byte_idx == 4'd1 && has_regs) begin
        r_a <= imem_data[7:4];
        r_b <= imem_data[3:0];
      end
      if (vc_hit) val_c[{vc_off, 3'b000} +: 8] <= imem_data;
      if (last_byte) begin
        val_p <= pc + {60'd0, ilen};
        stat  <= icode_bad ? STAT_INS : ((cur_icode == 4'h0) ? STAT_HLT : STAT_AOK);
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle Y86-64 fetch stage for the SEQ datapath. Holds the architectural PC and pulls instruction bytes one at a time from a byte-wide instruction memory. Splits each instruction into icode/ifun/rA/rB/valC and computes valP. Hands the result downstream through a valid/ready handshake, then waits for pc_update to return the next PC.

## Interface

- RESET_PC, 64'd0, PC value loaded on reset.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  byte read request, registered.
- imem_addr  out  64  byte address (pc + byte_idx, mod 2^64).
- imem_ack  in  1  read complete this cycle; imem_data/imem_err valid.
- imem_data  in  8  returned byte.
- imem_err  in  1  address error on this read.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- in_code  out  4  icode.
- ifun  out  4  function code.
- r_a, r_b  out  4 each  register IDs (4'hF when unused).
- val_c  out  64  constant word (0 when unused).
- val_p  out  64  pc + instruction length.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- pc_load  in  1  load next PC.
- pc_next  in  64  next PC (from pc_update p_ctr_final).
- pc  out  64  current PC.

## Operation

- States: FETCH, VALID, WAIT_PC, HALT.
- Instruction lengths by icode:
  - 0, 1, 9: 1 byte.
  - 2, 6, A, B: 2 bytes.
  - 7, 8: 9 bytes.
  - 3, 4, 5: 10 bytes.
  - icode > B: invalid.
- FETCH:
  - imem_req=1 with imem_addr = pc + byte_idx; byte_idx starts at 0.
  - On imem_ack, store the byte and increment byte_idx.
  - The length is fixed by byte 0.
  - When byte_idx reaches the length, go to VALID.
- Byte layout:
  - Byte 0: in_code = [7:4], ifun = [3:0].
  - Register byte: r_a = [7:4], r_b = [3:0].
  - val_c is little-endian: bytes 1..8 for icode 7/8, bytes 2..9 for icode 3/4/5.
- Invalid icode:
  - Byte 0 only is read; stat=4, r_a=r_b=F, val_c=0, val_p=pc+1.
  - Go to VALID.
- imem_err with imem_ack:
  - Abort the fetch and discard the byte; stat=3, go to VALID.
  - Unfetched fields are F (registers) or 0 (val_c); val_p = pc + byte_idx.
- icode 0 (halt): stat=2; otherwise stat=1.
- VALID:
  - out_valid=1; all outputs held stable until out_ready.
  - On out_valid & out_ready:
    - stat != 1: go to HALT.
    - stat = 1 and pc_load=1 in the same cycle: load pc_next, go to FETCH.
    - stat = 1 and pc_load=0: go to WAIT_PC.
- WAIT_PC: on pc_load, pc <= pc_next, byte_idx <= 0, go to FETCH.
- pc_load is ignored in FETCH and in HALT.
- HALT: imem_req=0, out_valid=0; stays until reset.
- All address and val_p arithmetic is 64-bit and wraps mod 2^64.

## Timing

- Reset (asynchronous, any state, including mid-request):
  - pc = RESET_PC; state = FETCH (entered on the first edge after release).
  - imem_req=0, out_valid=0, stat=1, in_code=0, ifun=0, r_a=r_b=F, val_c=0, val_p=0.
  - Any partially fetched bytes are discarded.
- Request handshake:
  - imem_req is asserted the cycle after FETCH entry.
  - imem_req and imem_addr are held until the edge on which imem_ack=1 is sampled.
  - The next address is presented on the following cycle.
- Latency: with imem_ack tied high, an N-byte instruction raises out_valid N+1 cycles after FETCH entry.
- Each cycle of imem_ack=0 adds one cycle of latency.
- imem_ack while imem_req=0 is ignored.
- out_valid deasserts the cycle after acceptance.

## Test plan

- irmovq at pc=0, bytes 30 F0 EF CD AB 89 67 45 23 01, zero-wait ack:
  - in_code=3, ifun=0, r_a=F, r_b=0, val_c=64'h0123456789ABCDEF, val_p=10, stat=1.
  - out_valid rises 11 cycles after FETCH entry.
- pc_load pc_next=0x20, then jne bytes 74 40 00 00 00 00 00 00 00 with 2 wait cycles per byte:
  - imem_addr steps 0x20..0x28; in_code=7, ifun=4, val_c=0x40, val_p=0x29.
- OPq 60 23 with out_ready low for 5 cycles:
  - Outputs are stable and out_valid stays high; one acceptance only.
  - pc_load together with out_ready goes straight to FETCH.
- Halt byte 00: stat=2, val_p=pc+1. After acceptance imem_req stays 0 and pc_load is ignored.
- Invalid byte C0: stat=4 after 1 byte read. imem_err on byte 3 of rmmovq: stat=3, val_p=pc+3.
- Assert reset_n=0 while in FETCH at byte 5:
  - Same cycle: imem_req=0 and pc=RESET_PC.
  - After release: refetches from byte 0.
